// File: rtl/rf_dump_if.sv
// Output stream of the register-file dump sequencer: one captured register
// value with its address, offered under a valid/ready handshake.
interface rf_dump_if;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_addr;

  // Producer side (the dump sequencer)
  modport master (
    output out_valid,
    output out_data,
    output out_addr,
    input  out_ready
  );

  // Consumer side (debug UART, trace buffer, ...)
  modport slave (
    input  out_valid,
    input  out_data,
    input  out_addr,
    output out_ready
  );
endinterface

// File: rtl/rf_dump.sv
// Register-file debug dump sequencer. Walks addresses FIRST_REG..LAST_REG
// through one RF read port, captures each value, and offers it with its
// address on a valid/ready stream. busy tells the upper level to steer the
// shared RF read-address mux to ra_o instead of the decode stage.
module rf_dump #(
  parameter int unsigned FIRST_REG = 0,
  parameter int unsigned LAST_REG  = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic [4:0]  ra_o,
  input  logic [31:0] rd_i,
  rf_dump_if.master   out_if,
  output logic        busy,
  output logic        done
);

  localparam logic [4:0] FIRST_ADDR = 5'(FIRST_REG);
  localparam logic [4:0] LAST_ADDR  = 5'(LAST_REG);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [4:0]  ptr_r;
  logic [4:0]  ptr_nxt_s;
  logic [31:0] data_r;
  logic [4:0]  addr_r;
  logic        valid_r;
  logic        busy_r;
  logic        done_r;

  // Next-state and address-pointer decode; ptr only advances on a handshake
  // that is not the last one, so it never wraps past LAST_REG.
  always_comb begin
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    case (state_r)
      IDLE: begin
        ptr_nxt_s = FIRST_ADDR;
        if (start) begin
          state_nxt_s = READ;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      READ: begin
        if (abort) begin
          state_nxt_s = IDLE;
          ptr_nxt_s   = FIRST_ADDR;
        end else begin
          state_nxt_s = SEND;
        end
      end
      SEND: begin
        if (abort) begin
          state_nxt_s = IDLE;
          ptr_nxt_s   = FIRST_ADDR;
        end else if (out_if.out_ready) begin
          if (ptr_r == LAST_ADDR) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = READ;
            ptr_nxt_s   = ptr_r + 5'd1;
          end
        end else begin
          state_nxt_s = SEND;
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
        ptr_nxt_s   = FIRST_ADDR;
      end
      default: begin
        state_nxt_s = IDLE;
        ptr_nxt_s   = FIRST_ADDR;
      end
    endcase
  end

  // State, pointer and state-derived output flags, registered so no input
  // reaches an output combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      ptr_r   <= FIRST_ADDR;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ptr_r   <= ptr_nxt_s;
      valid_r <= (state_nxt_s == SEND);
      busy_r  <= (state_nxt_s == READ) || (state_nxt_s == SEND);
      done_r  <= (state_nxt_s == DONE);
    end
  end

  // Capture the RF value in READ; held unchanged through SEND backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_r <= 32'd0;
      addr_r <= 5'd0;
    end else if (state_r == READ) begin
      data_r <= rd_i;
      addr_r <= ptr_r;
    end
  end

  assign ra_o             = ptr_r;
  assign out_if.out_valid = valid_r;
  assign out_if.out_data  = data_r;
  assign out_if.out_addr  = addr_r;
  assign busy             = busy_r;
  assign done             = done_r;

endmodule

// File: tb/tb_rf_dump.sv
// Directed bench for rf_dump: a full-range instance (0..31) and a
// single-register instance (8..8), each fed from a modelled register file.
module tb_rf_dump;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [4:0]  ra_a;
  logic [31:0] rd_a;
  logic        busy;
  logic        done;

  logic        start_b;
  logic        abort_b;
  logic [4:0]  ra_b;
  logic [31:0] rd_b;
  logic        busy_b;
  logic        done_b;

  logic [31:0] regs [32];

  int n_checks;
  int n_fail;

  rf_dump_if oif_a ();
  rf_dump_if oif_b ();

  rf_dump #(.FIRST_REG(0), .LAST_REG(31)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .abort  (abort),
    .ra_o   (ra_a),
    .rd_i   (rd_a),
    .out_if (oif_a.master),
    .busy   (busy),
    .done   (done)
  );

  rf_dump #(.FIRST_REG(8), .LAST_REG(8)) dut_b (
    .clk    (clk),
    .rst    (rst),
    .start  (start_b),
    .abort  (abort_b),
    .ra_o   (ra_b),
    .rd_i   (rd_b),
    .out_if (oif_b.master),
    .busy   (busy_b),
    .done   (done_b)
  );

  // combinational register-file read ports; register 0 is hard zero
  assign rd_a = regs[ra_a];
  assign rd_b = regs[ra_b];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rf_val(input int k);
    return (k == 0) ? 32'd0 : 32'h1000_0000 + 32'(k);
  endfunction

  // Full 0..31 dump on instance A, checking order, data, stability under
  // backpressure and a single done pulse.
  task automatic run_dump(input string tag, input int ready_pct, input bit spam,
                          input bit check_done_cyc);
    int exp_k;
    int cyc;
    int n_done;
    int done_cyc;
    bit holding;
    bit finished;
    bit rdy;
    logic [31:0] hold_d;
    logic [4:0]  hold_a;
    exp_k = 0; n_done = 0; done_cyc = 0; holding = 1'b0; finished = 1'b0;
    hold_d = 32'd0; hold_a = 5'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    check({tag, " busy_in_read"}, 32'(busy), 32'd1);
    while (!finished && cyc < 1000) begin
      rdy = ($urandom_range(0, 99) < 32'(ready_pct));
      oif_a.out_ready = rdy;
      if (spam) start = (cyc % 3 == 0);
      if (holding) begin
        check({tag, " hold_valid"}, 32'(oif_a.out_valid), 32'd1);
        check({tag, " hold_data"}, oif_a.out_data, hold_d);
        check({tag, " hold_addr"}, 32'(oif_a.out_addr), 32'(hold_a));
      end
      if (oif_a.out_valid && rdy) begin
        check({tag, " item_addr"}, 32'(oif_a.out_addr), 32'(exp_k));
        check({tag, " item_data"}, oif_a.out_data, rf_val(exp_k));
        exp_k++;
        holding = 1'b0;
      end else if (oif_a.out_valid) begin
        holding = 1'b1;
        hold_d  = oif_a.out_data;
        hold_a  = oif_a.out_addr;
      end else begin
        holding = 1'b0;
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
        if (spam) start = 1'b1;
      end else if (n_done > 0) begin
        finished = 1'b1;
        start = 1'b0;
      end
      if (!finished) begin
        tick();
        cyc++;
      end
    end
    oif_a.out_ready = 1'b0;
    start = 1'b0;
    check({tag, " finished_in_budget"}, 32'(finished), 32'd1);
    check({tag, " item_count"}, 32'(exp_k), 32'd32);
    check({tag, " done_count"}, 32'(n_done), 32'd1);
    if (check_done_cyc) check({tag, " done_cycle"}, 32'(done_cyc), 32'd65);
    check({tag, " idle_busy"}, 32'(busy), 32'd0);
    check({tag, " idle_ra"}, 32'(ra_a), 32'd0);
    tick();
    check({tag, " no_restart_busy"}, 32'(busy), 32'd0);
    check({tag, " no_restart_done"}, 32'(done), 32'd0);
  endtask

  // Start a dump on A and stop at the negedge where addr `target` is offered,
  // with out_ready already dropped so no handshake happens.
  task automatic advance_to_addr(input string tag, input int target);
    int cyc;
    bit hit;
    hit = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    oif_a.out_ready = 1'b1;
    for (cyc = 0; cyc < 200 && !hit; cyc++) begin
      if (oif_a.out_valid && (32'(oif_a.out_addr) == 32'(target))) begin
        oif_a.out_ready = 1'b0;
        hit = 1'b1;
      end else begin
        tick();
      end
    end
    check({tag, " reached_addr"}, 32'(hit), 32'd1);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int k = 0; k < 32; k++) regs[k] = rf_val(k);
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    start_b = 1'b0; abort_b = 1'b0;
    oif_a.out_ready = 1'b0;
    oif_b.out_ready = 1'b0;
    tick();
    tick();

    // reset state
    check("rst valid", 32'(oif_a.out_valid), 32'd0);
    check("rst data", oif_a.out_data, 32'd0);
    check("rst addr", 32'(oif_a.out_addr), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst ra", 32'(ra_a), 32'd0);
    check("rst ra_b", 32'(ra_b), 32'd8);
    rst = 1'b0;
    tick();

    // full dump, ready held high
    run_dump("full", 100, 1'b0, 1'b1);

    // same dump under random backpressure
    run_dump("bp", 30, 1'b0, 1'b0);

    // single-register instance 8..8
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    check("b c1 busy", 32'(busy_b), 32'd1);
    check("b c1 ra", 32'(ra_b), 32'd8);
    check("b c1 valid", 32'(oif_b.out_valid), 32'd0);
    oif_b.out_ready = 1'b1;
    tick();
    check("b c2 valid", 32'(oif_b.out_valid), 32'd1);
    check("b c2 addr", 32'(oif_b.out_addr), 32'd8);
    check("b c2 data", oif_b.out_data, 32'h1000_0008);
    check("b c2 done", 32'(done_b), 32'd0);
    tick();
    oif_b.out_ready = 1'b0;
    check("b c3 done", 32'(done_b), 32'd1);
    check("b c3 valid", 32'(oif_b.out_valid), 32'd0);
    check("b c3 busy", 32'(busy_b), 32'd0);
    tick();
    check("b c4 done", 32'(done_b), 32'd0);
    check("b c4 ra", 32'(ra_b), 32'd8);

    // abort in SEND at addr 5 with ready low
    advance_to_addr("abort", 5);
    tick();
    check("abort stall valid", 32'(oif_a.out_valid), 32'd1);
    check("abort stall addr", 32'(oif_a.out_addr), 32'd5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort valid", 32'(oif_a.out_valid), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort ra", 32'(ra_a), 32'd0);
    tick();
    check("abort done later", 32'(done), 32'd0);
    check("abort stays idle", 32'(busy), 32'd0);
    run_dump("after_abort", 100, 1'b0, 1'b1);

    // reset mid-dump at addr 12, start held during reset
    advance_to_addr("rstmid", 12);
    rst = 1'b1;
    start = 1'b1;
    tick();
    check("rstmid valid", 32'(oif_a.out_valid), 32'd0);
    check("rstmid data", oif_a.out_data, 32'd0);
    check("rstmid addr", 32'(oif_a.out_addr), 32'd0);
    check("rstmid busy", 32'(busy), 32'd0);
    check("rstmid done", 32'(done), 32'd0);
    check("rstmid ra", 32'(ra_a), 32'd0);
    tick();
    check("rstmid held busy", 32'(busy), 32'd0);
    rst = 1'b0;
    start = 1'b0;
    tick();
    check("rstmid release busy", 32'(busy), 32'd0);
    run_dump("after_rst", 100, 1'b0, 1'b1);

    // start pulsed during the dump and in the DONE cycle
    run_dump("spam", 100, 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
